// File: rtl/hdmi_fetch_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_fetch_pkg
// Shared definitions for the 720p line-fetch controller: frame geometry,
// line-buffer depth and the enumerations used by the fetch state machine and
// the pending-start bookkeeping.
// No ports (package).
// -----------------------------------------------------------------------------
package hdmi_fetch_pkg;

  localparam int unsigned PIXELS_PER_LINE = 1280;
  localparam int unsigned WORDS_PER_LINE  = 640;
  localparam int unsigned ACTIVE_LINES    = 720;

  // Two ping-pong banks of one line each.
  localparam int unsigned LINE_BUF_DEPTH  = 2 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } fetch_state_e;

  // What kind of start event is parked while a fetch is still running.
  typedef enum logic {
    START_SCREEN = 1'b0,
    START_LINE   = 1'b1
  } start_kind_e;

endpackage

// File: rtl/hdmi_line_buffer.sv
// -----------------------------------------------------------------------------
// hdmi_line_buffer
// Dual-bank line store, 2 x 640 words of 32 bits, built as one simple
// dual-port RAM with a synchronous read. Bank 1 sits above bank 0.
// Ports:
//   pixelClockIn        single clock for both ports
//   wr_en               write strobe
//   wr_bank, wr_word    write bank select and word index 0..639
//   wr_data             write data
//   rd_bank, rd_word    read bank select and word index 0..639
//   rd_data             registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module hdmi_line_buffer
  import hdmi_fetch_pkg::*;
(
  input  logic        pixelClockIn,
  input  logic        wr_en,
  input  logic        wr_bank,
  input  logic [9:0]  wr_word,
  input  logic [31:0] wr_data,
  input  logic        rd_bank,
  input  logic [9:0]  rd_word,
  output logic [31:0] rd_data
);

  logic [31:0] mem [LINE_BUF_DEPTH];
  logic [10:0] wr_addr;
  logic [10:0] rd_addr;
  logic [31:0] rd_data_q;

  // Flatten bank/word into a single RAM address; bank 1 is offset by a line.
  always_comb begin
    wr_addr = wr_bank ? (11'(wr_word) + 11'(WORDS_PER_LINE)) : 11'(wr_word);
    rd_addr = rd_bank ? (11'(rd_word) + 11'(WORDS_PER_LINE)) : 11'(rd_word);
  end

  // Plain RAM template: no reset on storage or read register so it maps to
  // block RAM; contents survive a controller reset.
  always_ff @(posedge pixelClockIn) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hdmi_line_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_line_fetch_ctrl
// Fetches one 1280-pixel RGB565 line per request from the frame buffer into a
// ping-pong line buffer, using fixed-length bus bursts, and serves pixels to
// the timing generator with one cycle of latency.
// Ports:
//   pixelClockIn, reset        clock and synchronous active-high reset
//   enable                     fetch and display enable
//   frameBase                  frame-buffer byte base (taken on newScreen)
//   newScreen, nextLine        start pulses from the timing generator
//   requestPixel, pixelIndex,
//   lineIndex                  pixel read request and coordinates
//   fetchRequest, fetchAddress,
//   fetchBurstSize             burst request towards the bus master
//   fetchGrant, fetchDataValid,
//   fetchData                  bus grant and returned words
//   redOut, greenOut, blueOut  RGB565 pixel output
//   underrun                   sticky: a start came while a fetch was running
//   busy                       a line fetch is in progress
// -----------------------------------------------------------------------------
module hdmi_line_fetch_ctrl
  import hdmi_fetch_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 16,
  parameter int unsigned LINE_STRIDE = 2560
) (
  input  logic        pixelClockIn,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] frameBase,
  input  logic        newScreen,
  input  logic        nextLine,
  input  logic        requestPixel,
  input  logic [10:0] pixelIndex,
  input  logic [9:0]  lineIndex,
  output logic        fetchRequest,
  output logic [31:0] fetchAddress,
  output logic [7:0]  fetchBurstSize,
  input  logic        fetchGrant,
  input  logic        fetchDataValid,
  input  logic [31:0] fetchData,
  output logic [4:0]  redOut,
  output logic [5:0]  greenOut,
  output logic [4:0]  blueOut,
  output logic        underrun,
  output logic        busy
);

  // Byte step between bursts; a constant shift, so no multiplier is built.
  localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS) << 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  line_addr_q, line_addr_d;
  logic [31:0]  burst_addr_q, burst_addr_d;
  logic [9:0]   fetch_line_q, fetch_line_d;
  logic [9:0]   word_cnt_q, word_cnt_d;
  logic [7:0]   burst_cnt_q, burst_cnt_d;
  logic         pending_q, pending_d;
  start_kind_e  pending_kind_q, pending_kind_d;
  logic [31:0]  pending_base_q, pending_base_d;
  logic         underrun_q, underrun_d;
  logic         pix_valid_q, pix_valid_d;
  logic         pix_half_q, pix_half_d;

  logic         screen_evt;
  logic         line_evt;
  logic         start_go;
  logic         start_screen;
  logic [31:0]  start_base;
  logic         wr_en;
  logic [31:0]  rd_data;
  logic [15:0]  pix_word;

  // Start events: a new screen always counts, a next-line only while there
  // is still a line below the current one.
  always_comb begin
    screen_evt = enable && newScreen;
    line_evt   = enable && nextLine && (fetch_line_q < 10'(ACTIVE_LINES - 1));
  end

  // Next-state logic. While busy, a start is parked (newest wins) and flags
  // underrun. When idle, a fresh start takes priority over a parked one; the
  // parked one therefore launches in the first idle cycle after a fetch ends.
  // A burst always runs to completion; at its end a low enable sends the FSM
  // home instead of asking for the next burst.
  always_comb begin
    state_d        = state_q;
    line_addr_d    = line_addr_q;
    burst_addr_d   = burst_addr_q;
    fetch_line_d   = fetch_line_q;
    word_cnt_d     = word_cnt_q;
    burst_cnt_d    = burst_cnt_q;
    pending_d      = pending_q;
    pending_kind_d = pending_kind_q;
    pending_base_d = pending_base_q;
    underrun_d     = underrun_q;
    start_go       = 1'b0;
    start_screen   = 1'b0;
    start_base     = frameBase;

    if (state_q != ST_IDLE) begin
      if (screen_evt || line_evt) begin
        underrun_d     = 1'b1;
        pending_d      = 1'b1;
        pending_kind_d = screen_evt ? START_SCREEN : START_LINE;
        pending_base_d = frameBase;
      end
    end else begin
      if (screen_evt || line_evt) begin
        start_go     = 1'b1;
        start_screen = screen_evt;
        start_base   = frameBase;
        if (screen_evt) begin
          underrun_d = 1'b0;
        end
      end else if (pending_q) begin
        start_go     = 1'b1;
        start_screen = (pending_kind_q == START_SCREEN);
        start_base   = pending_base_q;
      end
      pending_d = 1'b0;
    end

    if (!enable) begin
      pending_d = 1'b0;
    end

    if (start_go) begin
      if (start_screen) begin
        line_addr_d  = start_base;
        fetch_line_d = '0;
      end else begin
        line_addr_d  = line_addr_q + 32'(LINE_STRIDE);
        fetch_line_d = fetch_line_q + 10'd1;
      end
      burst_addr_d = line_addr_d;
      word_cnt_d   = '0;
      burst_cnt_d  = '0;
      state_d      = ST_REQ;
    end

    case (state_q)
      ST_REQ: begin
        if (fetchGrant) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (fetchDataValid) begin
          word_cnt_d  = word_cnt_q + 10'd1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (word_cnt_q == 10'(WORDS_PER_LINE - 1)) begin
            word_cnt_d  = '0;
            burst_cnt_d = '0;
            state_d     = ST_IDLE;
          end else if (burst_cnt_q == 8'(BURST_WORDS - 1)) begin
            burst_cnt_d  = '0;
            burst_addr_d = burst_addr_q + BURST_BYTES;
            state_d      = enable ? ST_REQ : ST_IDLE;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Pixel side: remember which half-word was asked for and whether the
  // request was live, so the registered RAM output can be formatted next
  // cycle. Out-of-range coordinates are treated as blanking.
  always_comb begin
    pix_valid_d = requestPixel && enable &&
                  (pixelIndex < 11'(PIXELS_PER_LINE)) &&
                  (lineIndex < 10'(ACTIVE_LINES));
    pix_half_d  = pixelIndex[0];
  end

  // State register; a reset abandons any burst in flight.
  always_ff @(posedge pixelClockIn) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      line_addr_q    <= '0;
      burst_addr_q   <= '0;
      fetch_line_q   <= '0;
      word_cnt_q     <= '0;
      burst_cnt_q    <= '0;
      pending_q      <= 1'b0;
      pending_kind_q <= START_SCREEN;
      pending_base_q <= '0;
      underrun_q     <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_half_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_addr_q    <= line_addr_d;
      burst_addr_q   <= burst_addr_d;
      fetch_line_q   <= fetch_line_d;
      word_cnt_q     <= word_cnt_d;
      burst_cnt_q    <= burst_cnt_d;
      pending_q      <= pending_d;
      pending_kind_q <= pending_kind_d;
      pending_base_q <= pending_base_d;
      underrun_q     <= underrun_d;
      pix_valid_q    <= pix_valid_d;
      pix_half_q     <= pix_half_d;
    end
  end

  // Only words that arrive inside a granted burst land in the buffer; the
  // reset term keeps a word coinciding with reset out of the RAM.
  assign wr_en = (state_q == ST_XFER) && fetchDataValid && !reset;

  hdmi_line_buffer u_line_buffer (
    .pixelClockIn (pixelClockIn),
    .wr_en        (wr_en),
    .wr_bank      (fetch_line_q[0]),
    .wr_word      (word_cnt_q),
    .wr_data      (fetchData),
    .rd_bank      (lineIndex[0]),
    .rd_word      (pixelIndex[10:1]),
    .rd_data      (rd_data)
  );

  // Pick the RGB565 half-word and blank it when the request was not live.
  always_comb begin
    pix_word = pix_half_q ? rd_data[31:16] : rd_data[15:0];
    redOut   = '0;
    greenOut = '0;
    blueOut  = '0;
    if (pix_valid_q) begin
      redOut   = pix_word[15:11];
      greenOut = pix_word[10:5];
      blueOut  = pix_word[4:0];
    end
  end

  assign fetchRequest   = (state_q == ST_REQ);
  assign fetchAddress   = burst_addr_q;
  assign fetchBurstSize = 8'(BURST_WORDS);
  assign underrun       = underrun_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hdmi_line_fetch_ctrl
// Directed sequence with random bus data and random bus timing, checked
// against a line-buffer model held as a plain array in the bench.
// -----------------------------------------------------------------------------
module tb_hdmi_line_fetch_ctrl;

  localparam int BW     = 16;
  localparam int STRIDE = 2560;
  localparam int WPL    = 640;

  logic        pixelClockIn;
  logic        reset;
  logic        enable;
  logic [31:0] frameBase;
  logic        newScreen;
  logic        nextLine;
  logic        requestPixel;
  logic [10:0] pixelIndex;
  logic [9:0]  lineIndex;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic [7:0]  fetchBurstSize;
  logic        fetchGrant;
  logic        fetchDataValid;
  logic [31:0] fetchData;
  logic [4:0]  redOut;
  logic [5:0]  greenOut;
  logic [4:0]  blueOut;
  logic        underrun;
  logic        busy;

  logic [31:0] modelMem [2][WPL];
  int          modelLine;
  int          wordPtr;
  int          testsRun;
  int          testsFailed;

  hdmi_line_fetch_ctrl #(
    .BURST_WORDS (BW),
    .LINE_STRIDE (STRIDE)
  ) dut (
    .pixelClockIn   (pixelClockIn),
    .reset          (reset),
    .enable         (enable),
    .frameBase      (frameBase),
    .newScreen      (newScreen),
    .nextLine       (nextLine),
    .requestPixel   (requestPixel),
    .pixelIndex     (pixelIndex),
    .lineIndex      (lineIndex),
    .fetchRequest   (fetchRequest),
    .fetchAddress   (fetchAddress),
    .fetchBurstSize (fetchBurstSize),
    .fetchGrant     (fetchGrant),
    .fetchDataValid (fetchDataValid),
    .fetchData      (fetchData),
    .redOut         (redOut),
    .greenOut       (greenOut),
    .blueOut        (blueOut),
    .underrun       (underrun),
    .busy           (busy)
  );

  // Free-running pixel clock, 10 ns period.
  initial pixelClockIn = 1'b0;
  always #5 pixelClockIn = ~pixelClockIn;

  // Last-resort guard in case something upstream stops making progress.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge pixelClockIn);
    #1;
  endtask

  // Single comparison point: counts, asserts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one pixel request and step a clock so the result is visible.
  task automatic applyStimulus(input logic req, input int px, input int ln);
    requestPixel = req;
    pixelIndex   = 11'(px);
    lineIndex    = 10'(ln);
    tick();
  endtask

  // Expected RGB565 half-word straight from the buffer model.
  function automatic logic [15:0] expPixel(input int ln, input int px);
    logic [31:0] w;
    w = modelMem[ln % 2][px / 2];
    return (px % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  task automatic checkPixel(input int ln, input int px);
    logic [15:0] e;
    applyStimulus(1'b1, px, ln);
    e = expPixel(ln, px);
    checkOutput("red",   32'(redOut),   32'(e[15:11]));
    checkOutput("green", 32'(greenOut), 32'(e[10:5]));
    checkOutput("blue",  32'(blueOut),  32'(e[4:0]));
  endtask

  task automatic pulseNewScreen(input logic [31:0] base);
    frameBase = base;
    newScreen = 1'b1;
    tick();
    newScreen = 1'b0;
  endtask

  task automatic pulseNextLine();
    nextLine = 1'b1;
    tick();
    nextLine = 1'b0;
  endtask

  // Wait, with a cycle budget, for the controller to raise a request.
  task automatic waitRequest();
    int n;
    n = 0;
    while (fetchRequest !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("requestSeen", 32'(fetchRequest), 32'd1);
  endtask

  // Return one word after a random gap and record it in the model.
  task automatic sendWord();
    logic [31:0] d;
    while ($urandom_range(0, 3) == 0) begin
      fetchDataValid = 1'b0;
      tick();
    end
    d = $urandom();
    if (modelLine == 0 && wordPtr == 5) d = 32'hAAAA_F800;
    modelMem[modelLine % 2][wordPtr] = d;
    wordPtr++;
    fetchData      = d;
    fetchDataValid = 1'b1;
    tick();
    fetchDataValid = 1'b0;
  endtask

  // One full burst: request check, optional grant hold-off, grant, data.
  task automatic serveBurst(input logic [31:0] expAddr, input int holdOff);
    waitRequest();
    checkOutput("fetchAddress", fetchAddress, expAddr);
    checkOutput("burstSize", 32'(fetchBurstSize), 32'(BW));
    for (int i = 0; i < holdOff; i++) begin
      tick();
      checkOutput("requestHeld", 32'(fetchRequest), 32'd1);
      checkOutput("addressHeld", fetchAddress, expAddr);
    end
    fetchGrant = 1'b1;
    tick();
    fetchGrant = 1'b0;
    checkOutput("requestAfterGrant", 32'(fetchRequest), 32'd0);
    for (int w = 0; w < BW; w++) sendWord();
  endtask

  // A whole line of bursts at the arithmetic address sequence; busy must be
  // low straight after the last word.
  task automatic serveLine(input logic [31:0] base, input int firstHold);
    wordPtr = 0;
    for (int b = 0; b < WPL / BW; b++) begin
      serveBurst(base + 32'(b * BW * 4), (b == 0) ? firstHold : int'($urandom_range(0, 3)));
    end
    checkOutput("busyAfterLine", 32'(busy), 32'd0);
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    modelLine      = 0;
    wordPtr        = 0;
    reset          = 1'b1;
    enable         = 1'b0;
    frameBase      = '0;
    newScreen      = 1'b0;
    nextLine       = 1'b0;
    requestPixel   = 1'b0;
    pixelIndex     = '0;
    lineIndex      = '0;
    fetchGrant     = 1'b0;
    fetchDataValid = 1'b0;
    fetchData      = '0;

    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rstRequest",  32'(fetchRequest), 32'd0);
    checkOutput("rstBusy",     32'(busy),         32'd0);
    checkOutput("rstUnderrun", 32'(underrun),     32'd0);
    checkOutput("rstAddress",  fetchAddress,      32'd0);
    checkOutput("rstColour",   {16'd0, redOut, greenOut, blueOut}, 32'd0);

    // Line 0 from a new screen, first grant held off 50 cycles.
    $display("[TB] line 0 fetch");
    enable = 1'b1;
    pulseNewScreen(32'h1000_0000);
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    modelLine = 0;
    serveLine(32'h1000_0000, 50);

    // Directed pixel decode, then random pixels of line 0, then blanking.
    checkPixel(0, 11);
    checkOutput("red11",   32'(redOut),   32'h15);
    checkOutput("green11", 32'(greenOut), 32'h15);
    checkOutput("blue11",  32'(blueOut),  32'h0A);
    for (int i = 0; i < 12; i++) checkPixel(0, int'($urandom_range(0, 1279)));
    applyStimulus(1'b0, 11, 0);
    checkOutput("blankNoRequest", {16'd0, redOut, greenOut, blueOut}, 32'd0);

    // Line 1 goes to bank 1; bank 0 still holds line 0.
    $display("[TB] line 1 fetch");
    pulseNextLine();
    modelLine = 1;
    serveLine(32'h1000_0A00, 1);
    for (int i = 0; i < 12; i++) checkPixel(1, int'($urandom_range(0, 1279)));
    for (int i = 0; i < 6; i++)  checkPixel(0, int'($urandom_range(0, 1279)));

    // Start while busy: underrun, then the parked start runs one idle cycle later.
    $display("[TB] underrun and pending start");
    pulseNextLine();
    modelLine = 2;
    waitRequest();
    pulseNextLine();
    checkOutput("underrunSet", 32'(underrun), 32'd1);
    serveLine(32'h1000_1400, 3);
    tick();
    checkOutput("pendingStartRequest", 32'(fetchRequest), 32'd1);
    checkOutput("pendingStartAddress", fetchAddress, 32'h1000_1E00);
    modelLine = 3;
    serveLine(32'h1000_1E00, 0);
    checkOutput("underrunSticky", 32'(underrun), 32'd1);
    for (int i = 0; i < 8; i++) checkPixel(3, int'($urandom_range(0, 1279)));
    for (int i = 0; i < 8; i++) checkPixel(2, int'($urandom_range(0, 1279)));

    // Idle new screen clears underrun; reset at word 7 aborts the burst.
    $display("[TB] reset mid-burst");
    pulseNewScreen(32'h2000_0000);
    checkOutput("underrunCleared", 32'(underrun), 32'd0);
    modelLine = 0;
    wordPtr   = 0;
    waitRequest();
    checkOutput("screenAddress", fetchAddress, 32'h2000_0000);
    fetchGrant = 1'b1;
    tick();
    fetchGrant = 1'b0;
    for (int w = 0; w < 7; w++) sendWord();
    reset          = 1'b1;
    fetchData      = 32'hDEAD_BEEF;
    fetchDataValid = 1'b1;
    tick();
    checkOutput("abortRequest", 32'(fetchRequest), 32'd0);
    checkOutput("abortBusy",    32'(busy),         32'd0);
    checkOutput("abortAddress", fetchAddress,      32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("strayBusy",    32'(busy),         32'd0);
      checkOutput("strayRequest", 32'(fetchRequest), 32'd0);
    end
    fetchDataValid = 1'b0;
    for (int px = 12; px < 16; px++) checkPixel(0, px);

    // Enable drop mid-burst: burst finishes, FSM idles, parked start is dropped.
    $display("[TB] enable drop mid-burst");
    pulseNewScreen(32'h3000_0000);
    wordPtr = 0;
    waitRequest();
    fetchGrant = 1'b1;
    tick();
    fetchGrant = 1'b0;
    for (int w = 0; w < 3; w++) sendWord();
    pulseNextLine();
    checkOutput("underrunMidBurst", 32'(underrun), 32'd1);
    enable = 1'b0;
    for (int w = 3; w < BW; w++) sendWord();
    checkOutput("disableBusy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("noPendingRequest", 32'(fetchRequest), 32'd0);
    end
    applyStimulus(1'b1, 4, 0);
    checkOutput("blankDisabled", {16'd0, redOut, greenOut, blueOut}, 32'd0);
    enable = 1'b1;
    for (int px = 0; px < 32; px += 5) checkPixel(0, px);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
